free_list_2a_2f: RTL and testbench

- Physical-register free list for the 2-wide rename stage.
- Circular FIFO of free physical tags:
  - up to 2 allocations per cycle to rename;
  - up to 2 frees per cycle from commit.
- Sits directly upstream of the rename-map storage. Allocated tags feed the map entries' data1_i/data2_i with write1/write2 enables.
- Holds a committed head pointer so a flush restores every speculatively allocated tag in one cycle.

---
 rtl/free_list_2a_2f_pkg.sv | 17 +
 rtl/free_list_2a_2f_ptr_ring_2p.sv | 34 +++
 rtl/free_list_2a_2f.sv | 102 ++++++++++
 tb/tb_free_list_2a_2f.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/free_list_2a_2f_pkg.sv
// Shared rename-stage constants: physical/architectural register counts,
// tag width and free-list pointer geometry.
package free_list_2a_2f_pkg;

  localparam int FL_NUM_PREGS = 64;
  localparam int FL_NUM_AREGS = 32;
  localparam int FL_TAG_W     = $clog2(FL_NUM_PREGS);
  localparam int FL_DEPTH     = FL_NUM_PREGS - FL_NUM_AREGS;
  localparam int FL_IDX_W     = $clog2(FL_DEPTH);
  localparam int FL_PTR_W     = FL_IDX_W + 1;

  // Number of set bits in a pair of per-slot strobes (0, 1 or 2).
  function automatic logic [1:0] cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/free_list_2a_2f_ptr_ring_2p.sv
// Wrap-bit ring pointer advancing by 0/1/2 per cycle, with an optional load
// and a distance output (ref_i - ptr) used for occupancy arithmetic.
module ptr_ring_2p #(
  parameter int               PTR_W   = 6,
  parameter logic [PTR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc_i,
  input  logic             load_i,
  input  logic [PTR_W-1:0] load_val_i,
  input  logic [PTR_W-1:0] ref_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic [PTR_W-1:0] ptr_nxt_o,
  output logic [PTR_W-1:0] dist_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q + PTR_W'(inc_i);
    if (load_i) ptr_d = load_val_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= RST_VAL;
    else      ptr_q <= ptr_d;
  end

  assign ptr_o     = ptr_q;
  assign ptr_nxt_o = ptr_d;
  assign dist_o    = ref_i - ptr_q;

endmodule

// File: rtl/free_list_2a_2f.sv
// Physical-tag free list for 2-wide rename: 2 allocs + 2 frees per cycle,
// committed head snapshot restores all speculative allocations on flush.
module free_list_2a_2f
  import free_list_2a_2f_pkg::*;
#(
  parameter int NUM_PREGS = FL_NUM_PREGS,
  parameter int NUM_AREGS = FL_NUM_AREGS,
  parameter int TAG_WIDTH = FL_TAG_W,
  localparam int DEPTH    = NUM_PREGS - NUM_AREGS,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int PTR_W    = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc1_req_i,
  input  logic                 alloc2_req_i,
  output logic                 alloc_ok_o,
  output logic [TAG_WIDTH-1:0] alloc1_tag_o,
  output logic [TAG_WIDTH-1:0] alloc2_tag_o,
  input  logic                 free1_en_i,
  input  logic [TAG_WIDTH-1:0] free1_tag_i,
  input  logic                 free2_en_i,
  input  logic [TAG_WIDTH-1:0] free2_tag_i,
  input  logic                 commit1_i,
  input  logic                 commit2_i,
  input  logic                 flush_i,
  output logic [PTR_W-1:0]     count_o,
  output logic                 empty_o,
  output logic                 overflow_err_o
);

  logic [TAG_WIDTH-1:0] mem_q [DEPTH];
  logic                 ovf_q, ovf_d;

  logic [PTR_W-1:0] head_ptr, head_nxt, chead_ptr, chead_nxt, tail_ptr;
  logic [PTR_W-1:0] count, spec_cnt, cnt_after, space;
  logic [PTR_W-1:0] tail_nxt_unused, tail_dist_unused;
  logic [1:0]       nreq, pop_n, acc_n, commit_n;
  logic             alloc_ok, acc1, acc2;
  logic [IDX_W-1:0] hidx, hidx1, widx1, widx2;

  ptr_ring_2p #(.PTR_W(PTR_W), .RST_VAL('0)) u_head (
    .clk(clk), .rst(rst), .inc_i(pop_n), .load_i(flush_i),
    .load_val_i(chead_nxt), .ref_i(tail_ptr),
    .ptr_o(head_ptr), .ptr_nxt_o(head_nxt), .dist_o(count)
  );

  ptr_ring_2p #(.PTR_W(PTR_W), .RST_VAL('0)) u_chead (
    .clk(clk), .rst(rst), .inc_i(commit_n), .load_i(1'b0),
    .load_val_i('0), .ref_i(head_ptr),
    .ptr_o(chead_ptr), .ptr_nxt_o(chead_nxt), .dist_o(spec_cnt)
  );

  ptr_ring_2p #(.PTR_W(PTR_W), .RST_VAL(PTR_W'(DEPTH))) u_tail (
    .clk(clk), .rst(rst), .inc_i(acc_n), .load_i(1'b0),
    .load_val_i('0), .ref_i('0),
    .ptr_o(tail_ptr), .ptr_nxt_o(tail_nxt_unused), .dist_o(tail_dist_unused)
  );

  assign nreq     = cnt2(alloc1_req_i, alloc2_req_i);
  assign commit_n = cnt2(commit1_i, commit2_i);
  assign alloc_ok = rst && !flush_i && (count >= PTR_W'(nreq));
  assign pop_n    = alloc_ok ? nreq : 2'd0;

  assign hidx  = head_ptr[IDX_W-1:0];
  assign hidx1 = hidx + IDX_W'(1);

  // Room for frees is judged against where head lands after this edge,
  // so pops (or a flush rewind) in the same cycle are accounted for.
  assign cnt_after = tail_ptr - head_nxt;
  assign space     = PTR_W'(DEPTH) - cnt_after;
  assign acc1      = free1_en_i && (space != '0);
  assign acc2      = free2_en_i && (space > PTR_W'(acc1));
  assign acc_n     = cnt2(acc1, acc2);
  assign ovf_d     = ovf_q | (free1_en_i & ~acc1) | (free2_en_i & ~acc2);

  assign widx1 = tail_ptr[IDX_W-1:0];
  assign widx2 = acc1 ? widx1 + IDX_W'(1) : widx1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_WIDTH'(NUM_AREGS + i);
      ovf_q <= 1'b0;
    end else begin
      if (acc1) mem_q[widx1] <= free1_tag_i;
      if (acc2) mem_q[widx2] <= free2_tag_i;
      ovf_q <= ovf_d;
    end
  end

  assign alloc_ok_o     = alloc_ok;
  assign alloc1_tag_o   = mem_q[hidx];
  assign alloc2_tag_o   = alloc1_req_i ? mem_q[hidx1] : mem_q[hidx];
  assign count_o        = count;
  assign empty_o        = (count == '0);
  assign overflow_err_o = ovf_q;

  // The committed head can only retire tags that were actually handed out.
  a_commit_le_spec: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(commit_n) <= spec_cnt);

endmodule

// File: tb/tb_free_list_2a_2f.sv
// Directed + model-driven bench for free_list_2a_2f; expected responses are
// queued at stimulus time and compared by an independent negedge monitor.
module tb_free_list_2a_2f;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a1 = 0, a2 = 0, f1e = 0, f2e = 0, c1 = 0, c2 = 0, fl = 0;
  logic [5:0] f1t = '0, f2t = '0;
  logic       ok, emp, ovf;
  logic [5:0] t1, t2, cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      nm;
    logic       ok;
    logic [5:0] t1, t2, cnt;
    logic       emp, ovf;
    bit         ck1, ck2;
  } exp_t;

  exp_t exp_q[$];

  free_list_2a_2f dut (
    .clk(clk), .rst(rst),
    .alloc1_req_i(a1), .alloc2_req_i(a2), .alloc_ok_o(ok),
    .alloc1_tag_o(t1), .alloc2_tag_o(t2),
    .free1_en_i(f1e), .free1_tag_i(f1t), .free2_en_i(f2e), .free2_tag_i(f2t),
    .commit1_i(c1), .commit2_i(c2), .flush_i(fl),
    .count_o(cnt), .empty_o(emp), .overflow_err_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.nm, ".ok"},    32'(ok),  32'(e.ok));
      check({e.nm, ".count"}, 32'(cnt), 32'(e.cnt));
      check({e.nm, ".empty"}, 32'(emp), 32'(e.emp));
      check({e.nm, ".ovf"},   32'(ovf), 32'(e.ovf));
      if (e.ck1) check({e.nm, ".tag1"}, 32'(t1), 32'(e.t1));
      if (e.ck2) check({e.nm, ".tag2"}, 32'(t2), 32'(e.t2));
    end
  end

  task automatic push(input string nm, input logic eok, input int et1, input int et2,
                      input int ecnt, input logic eovf, input bit ck1 = 1, input bit ck2 = 1);
    exp_t e;
    e.nm  = nm;
    e.ok  = eok;
    e.t1  = 6'(et1);
    e.t2  = 6'(et2);
    e.cnt = 6'(ecnt);
    e.emp = (ecnt == 0);
    e.ovf = eovf;
    e.ck1 = ck1;
    e.ck2 = ck2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    a1 = 0; a2 = 0; f1e = 0; f2e = 0; c1 = 0; c2 = 0; fl = 0;
    f1t = '0; f2t = '0;
  endtask

  // Asserted a cycle after an edge and checked before the next one: no clock involved.
  task automatic do_reset();
    tick();
    rst = 0;
    push("rst", 0, 32, 32, 32, 0);
  endtask

  int fl_q[$];
  int pool[$];
  int popped[$];

  initial begin
    tick();
    push("rst0", 0, 32, 32, 32, 0);

    // Flush restores to the committed head, including a same-cycle commit.
    tick(); rst = 1; a1 = 1; a2 = 1; push("rel",      1, 32, 33, 32, 0);
    tick(); a1 = 1; a2 = 1;          push("fl_a2",    1, 34, 35, 30, 0);
    tick(); c1 = 1; c2 = 1;          push("fl_cm",    1, 36, 36, 28, 0);
    tick(); fl = 1;                  push("fl_fl",    0, 36, 36, 28, 0);
    tick();                          push("fl_post",  1, 34, 34, 30, 0);
    tick(); a1 = 1; a2 = 1;          push("fl_a3",    1, 34, 35, 30, 0);
    tick(); fl = 1; c1 = 1;          push("fl_flc",   0, 36, 36, 28, 0);
    tick();                          push("fl_postc", 1, 35, 35, 29, 0);

    // Drain the whole list, then exercise the empty and count==1 boundaries.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tick(); rst = 1; a1 = 1; a2 = 1;
      push("dual", 1, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k, 0);
    end
    tick(); a1 = 1;                  push("empty_req",  0, 32, 33, 0, 0);
    tick();                          push("empty_idle", 1, 32, 32, 0, 0);
    tick(); f1e = 1; f1t = 6'd40;    push("free40",     1, 32, 32, 0, 0);
    tick(); a1 = 1; a2 = 1;          push("cnt1_both",  0, 40, 33, 1, 0);
    tick(); a2 = 1;                  push("cnt1_a2",    1, 40, 40, 1, 0);
    tick();                          push("cnt1_post",  1, 33, 33, 0, 0);

    // Full list with one pop: only one slot of room, so free2 is the one dropped.
    do_reset();
    tick(); rst = 1; a1 = 1; f1e = 1; f1t = 6'd7; f2e = 1; f2t = 6'd9;
    push("ovf_mix", 1, 32, 33, 32, 0);
    tick(); push("ovf_set",  1, 33, 33, 32, 1);
    tick(); push("ovf_hold", 1, 33, 33, 32, 1);
    for (int k = 0; k < 16; k++) begin
      tick(); a1 = 1; a2 = 1;
      push("ovf_drain", 1, 33 + 2 * k, (k == 15) ? 7 : 34 + 2 * k, 32 - 2 * k, 1);
    end

    // Free into a full list, then asynchronous reset clears the sticky error.
    do_reset();
    tick(); rst = 1; f1e = 1; f1t = 6'd5; push("full_free", 1, 32, 32, 32, 0);
    tick(); push("full_ovf",  1, 32, 32, 32, 1);
    tick(); push("full_hold", 1, 32, 32, 32, 1);
    tick(); rst = 0; push("arst", 0, 32, 32, 32, 0);
    tick(); rst = 1; push("arst_rel", 1, 32, 32, 32, 0);

    // Balanced random traffic against a queue model, wrapping the ring several times.
    for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
    for (int cyc = 0; cyc < 100; cyc++) begin
      bit   r1, r2, okv;
      int   nreq, sz, et1, et2, nf, lim;
      tick();
      r1   = 1'($urandom_range(0, 1));
      r2   = 1'($urandom_range(0, 1));
      nreq = int'(r1) + int'(r2);
      sz   = fl_q.size();
      okv  = (sz >= nreq);
      et1  = (sz > 0) ? fl_q[0] : 0;
      et2  = (r1 && sz > 1) ? fl_q[1] : et1;
      push("wrap", okv, et1, et2, sz, 0, okv && r1, okv && r2);
      a1 = r1;
      a2 = r2;
      popped.delete();
      if (okv) repeat (nreq) popped.push_back(fl_q.pop_front());
      lim = (pool.size() < 2) ? pool.size() : 2;
      nf  = $urandom_range(0, lim);
      if (nf == 2) begin
        f1e = 1; f1t = 6'(pool.pop_front());
        f2e = 1; f2t = 6'(pool.pop_front());
        fl_q.push_back(int'(f1t));
        fl_q.push_back(int'(f2t));
      end else if (nf == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          f2e = 1; f2t = 6'(pool.pop_front());
          fl_q.push_back(int'(f2t));
        end else begin
          f1e = 1; f1t = 6'(pool.pop_front());
          fl_q.push_back(int'(f1t));
        end
      end
      foreach (popped[j]) pool.push_back(popped[j]);
    end

    tick();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
